alu_ctrl_md: RTL
================

// Module: alu_ctrl_md
// PURPOSE
//  Next-generation ALU control for the RV32 core: decodes AluOp/funct3/funct7 into the
//  4-bit ALU select (defines.v ALU_* codes) and adds the M extension through an iterative
//  XLEN-parametrised multiply/divide engine with valid/ready handshakes. It sits beside
//  the main ALU in EX. The core stalls on busy and takes the result when out_valid is high.
// PARAMETERS
//  XLEN       32  operand/result width (>=8)
//  FAST_SPEC  1   1: div-by-zero and signed-overflow complete without iterating
// PORTS
//  clk        in   1     core clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  alu_op     in   2     00 ld/st, 01 branch, 10 R-type, 11 I-type
//  funct3     in   3     instruction[14:12]
//  funct7_5   in   1     instruction[30]
//  funct7_0   in   1     instruction[25] (M-extension flag when alu_op==10)
//  op_a       in   XLEN  rs1 value
//  op_b       in   XLEN  rs2 value
//  in_valid   in   1     EX holds a valid instruction
//  in_ready   out  1     engine idle, can accept an M op
//  alu_sel    out  4     ALU select for non-M ops (combinational)
//  is_md      out  1     current instruction is an M op (combinational)
//  busy       out  1     engine not in IDLE
//  result     out  XLEN  M-op result (registered)
//  out_valid  out  1     result valid
//  out_ready  in   1     core consumes result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; result=0, out_valid=0, busy=0. in_ready=1 after release.
//  - is_md = (alu_op==10) & funct7_0.
//  - alu_sel is pure combinational and defaults to ALU_ADD:
//      00 -> ADD; 01 -> SUB; 10 (funct7_0=0): 000 ADD/SUB(f7_5), 001 SLL, 010 SLT, 011 SLTU,
//      100 XOR, 101 SRL/SRA(f7_5), 110 OR, 111 AND.
//      11: same table, except 000 is always ADD and f7_5 selects only SRL/SRA.
//    SLT/SLTU ignore f7_5. Undefined combinations select ADD.
//  - Handshake:
//      in_ready = (state==IDLE).
//      Accept on the edge where in_valid & is_md & in_ready. op_a, op_b and funct3 are
//      latched then. Later input changes do not affect the op in flight.
//      Result hand-off happens on the edge where out_valid & out_ready.
//  - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//      IDLE: on accept, latch operands and take magnitudes for signed forms
//        (MULH: both signed; MULHSU: a signed, b unsigned; DIV/REM signed).
//        Load the counter with XLEN-1 and go to CALC.
//        Special cases (FAST_SPEC=1) go straight to DONE, result loaded on that edge:
//          div by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
//          DIV/REM with op_a=1<<(XLEN-1) and op_b=all ones: DIV -> op_a; REM -> 0.
//      CALC: one bit per cycle.
//        MUL*: shift-add into a 2*XLEN accumulator.
//        DIV*: restoring divide producing quotient and remainder.
//        Go to FIX when the counter reaches 0, so CALC lasts exactly XLEN cycles.
//      FIX, 1 cycle, applies signs:
//        product negated if the operand signs differ;
//        quotient negated if the signs differ;
//        remainder takes the dividend's sign.
//        Then selects the result: MUL low half; MULH/MULHSU/MULHU high half;
//        DIV/DIVU quotient; REM/REMU remainder. Go to DONE.
//      DONE: out_valid=1 and result held stable until out_ready. On handshake go to IDLE
//        and drop out_valid on that edge. A new op can be accepted one cycle later.
//  - Latency, counting the accept edge as cycle 0:
//      normal ops: out_valid first high in cycle XLEN+2 (34 at XLEN=32);
//      special cases: cycle 1.
//  - busy = (state!=IDLE).
//  - in_valid dropping mid-operation does not abort. Only rst_n aborts.
//  - Async reset mid-operation: discard all state immediately and return to IDLE with the
//    reset output values. A partial result must never appear on result.
//  - Arithmetic is modulo 2^XLEN. The multiply accumulator is 2*XLEN. The divider
//    remainder register is XLEN+1 for the trial subtract.
// TESTING
//  1. MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid rises exactly 34 cycles after accept.
//  2. 0xFFFFFFFF x 0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF.
//  3. DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, out_valid in cycle 1;
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//  4. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF. Hold out_ready low 3 cycles:
//     result and out_valid stay stable, in_ready stays 0.
//  5. rst_n pulsed low during CALC cycle 10 -> outputs 0 at once, in_ready=1 after release.
//     Next MUL 3x4 -> 12.
//  6. alu_sel sweep:
//     alu_op=10, f3=010, f7_5=0 -> ALU_SLT;
//     alu_op=11, f3=000, f7_5=1 -> ALU_ADD;
//     alu_op=11, f3=101, f7_5=1 -> ALU_SRA;
//     alu_op=01 -> ALU_SUB;
//     in_valid=1 with is_md=0 -> no accept, busy stays 0.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// ALU control decode for RV32 plus an iterative M-extension multiply/divide engine.
// Non-M ops get a combinational ALU select; M ops run through a valid/ready handshake.
module alu_ctrl_md #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FAST_SPEC = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_alu_op,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7_5,
    input  logic            i_funct7_0,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic [3:0]      o_alu_sel,
    output logic            o_is_md,
    output logic            o_busy,
    output logic [XLEN-1:0] o_result,
    output logic            o_out_valid,
    input  logic            i_out_ready
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t              r_state;
    logic [2:0]          r_f3;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_quo;
    logic [XLEN-1:0]     r_rem;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic [XLEN-1:0]     r_result;
    logic                r_out_valid;

    // ALU select decode
    always_comb begin
        o_alu_sel = ALU_ADD;
        unique case (i_alu_op)
            2'b00: o_alu_sel = ALU_ADD;
            2'b01: o_alu_sel = ALU_SUB;
            default: begin
                if (!(i_alu_op == 2'b10 && i_funct7_0)) begin
                    unique case (i_funct3)
                        3'b000: o_alu_sel = (i_alu_op == 2'b10 && i_funct7_5) ? ALU_SUB : ALU_ADD;
                        3'b001: o_alu_sel = ALU_SLL;
                        3'b010: o_alu_sel = ALU_SLT;
                        3'b011: o_alu_sel = ALU_SLTU;
                        3'b100: o_alu_sel = ALU_XOR;
                        3'b101: o_alu_sel = i_funct7_5 ? ALU_SRA : ALU_SRL;
                        3'b110: o_alu_sel = ALU_OR;
                        default: o_alu_sel = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    assign o_is_md     = (i_alu_op == 2'b10) && i_funct7_0;
    assign o_in_ready  = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_result    = r_result;
    assign o_out_valid = r_out_valid;

    logic            w_accept;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept  = i_in_valid && o_is_md && o_in_ready;
    // Signed operand a: MULH, MULHSU, DIV, REM; signed operand b: MULH, DIV, REM
    assign w_sign_a  = i_op_a[XLEN-1] && (i_funct3 == 3'b001 || i_funct3 == 3'b010 ||
                                          i_funct3 == 3'b100 || i_funct3 == 3'b110);
    assign w_sign_b  = i_op_b[XLEN-1] && (i_funct3 == 3'b001 || i_funct3 == 3'b100 ||
                                          i_funct3 == 3'b110);
    assign w_a_mag   = w_sign_a ? (~i_op_a + 1'b1) : i_op_a;
    assign w_b_mag   = w_sign_b ? (~i_op_b + 1'b1) : i_op_b;

    assign w_div_zero    = i_funct3[2] && (i_op_b == '0);
    assign w_ovf         = i_funct3[2] && !i_funct3[0] && (i_op_a == MIN_NEG) && (i_op_b == '1);
    assign w_special     = (FAST_SPEC != 0) && (w_div_zero || w_ovf);
    assign w_special_res = w_div_zero ? (i_funct3[1] ? i_op_a : '1)
                                      : (i_funct3[1] ? '0 : i_op_a);

    // Shift-add multiply step and restoring-divide step
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_b};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo_f;
    logic [XLEN-1:0]   w_rem_f;

    assign w_prod  = r_neg_res ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_f = r_neg_res ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_f = r_neg_rem ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_f3        <= '0;
            r_cnt       <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_f3      <= i_funct3;
                        r_cnt     <= CW'(XLEN - 1);
                        r_b       <= w_b_mag;
                        r_acc     <= {{XLEN{1'b0}}, w_a_mag};
                        r_quo     <= w_a_mag;
                        r_rem     <= '0;
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
                        if (w_special) begin
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (r_f3[2]) begin
                        r_rem <= w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (r_cnt == '0) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StFix: begin
                    unique case (r_f3)
                        3'b000:                 r_result <= w_prod[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: r_result <= w_prod[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         r_result <= w_quo_f;
                        default:                r_result <= w_rem_f;
                    endcase
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                default: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
